fetch_stage: RTL and testbench

- Instruction-fetch stage of the 20-bit-instruction pipelined CPU; sole producer of the pc and instruction that feed the FetchDecode register.
- Owns the program counter.
- Issues requests to the instruction memory with a req/valid handshake.
- Honours decode-stage stalls (nop from the hazard detection unit) and branch redirects (select_pc_mux / branch_address from the branch comparator and subtractor).

---
 rtl/cpu_fetch_pkg.sv | 26 ++
 rtl/fetch_pc_register.sv | 33 +++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage of the
// 20-bit-instruction pipelined CPU.
package cpu_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    KILL,
    HALTED
  } fetch_state_t;

  // Operation applied to the program counter on the next clock edge.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_op_t;

  localparam logic [4:0] HALT_OPCODE   = 5'b11111;
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam int         OPCODE_MSB    = 19;
  localparam int         OPCODE_LSB    = 15;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter register: hold, increment (modulo 2^PC_WIDTH) or load,
// with asynchronous active-high reset to RESET_PC.
module fetch_pc_register
  import cpu_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  pc_op_t              i_op,
  input  logic [PC_WIDTH-1:0] i_load_pc,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      case (i_op)
        PC_INC:  r_pc <= r_pc + 1'b1;
        PC_LOAD: r_pc <= i_load_pc;
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the pc, drives the req/valid instruction-memory
// handshake, honours stalls and branch redirects. Optional halt-opcode
// detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage
  import cpu_fetch_pkg::*;
#(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 20,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 20'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             nop,
  input  logic [1:0]             select_pc_mux,
  input  logic [PC_WIDTH-1:0]    branch_address,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_valid,
  output logic [PC_WIDTH-1:0]    pc_fetch,
  output logic [INSTR_WIDTH-1:0] instruction_fetch,
  output logic                   fetch_valid,
  output logic                   halted
);

  fetch_state_t            r_state, w_next_state;
  pc_op_t                  w_pc_op;
  logic [PC_WIDTH-1:0]     w_pc, w_load_pc, r_target;
  logic [PC_WIDTH-1:0]     r_pc_fetch;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic                    r_fetch_valid;
  logic                    w_stall, w_redirect;
  logic                    w_capture, w_drop_valid, w_latch_target;
  logic                    w_halt_set, w_halt_clr;

  assign w_stall    = (nop != 2'b00);
  assign w_redirect = (select_pc_mux == PC_SEL_BRANCH);

  fetch_pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .i_op      (w_pc_op),
    .i_load_pc (w_load_pc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_pc_op        = PC_HOLD;
    w_load_pc      = branch_address;
    w_capture      = 1'b0;
    w_drop_valid   = 1'b0;
    w_latch_target = 1'b0;
    w_halt_set     = 1'b0;
    w_halt_clr     = 1'b0;
    imem_req       = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = REQ;
        if (w_redirect) w_pc_op = PC_LOAD;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_valid && !w_redirect) begin
          w_capture = 1'b1;
          if (w_stall) begin
            w_next_state = HOLD;
          end else begin
            w_pc_op = PC_INC;
`ifdef FETCH_HALT_DETECT_EN
            if (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) w_next_state = HALTED;
`endif
          end
        end else begin
          w_drop_valid = 1'b1;
          if (w_redirect && imem_valid) begin
            w_pc_op = PC_LOAD;
          end else if (w_redirect) begin
            w_latch_target = 1'b1;
            w_next_state   = KILL;
          end
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_pc_op      = PC_LOAD;
          w_drop_valid = 1'b1;
          w_next_state = REQ;
        end else if (!w_stall) begin
          w_pc_op      = PC_INC;
          w_next_state = REQ;
`ifdef FETCH_HALT_DETECT_EN
          if (r_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) w_next_state = HALTED;
`endif
        end
      end
      KILL: begin
        // The outstanding request keeps its old address; its data is thrown away.
        imem_req     = 1'b1;
        w_drop_valid = 1'b1;
        if (w_redirect) w_latch_target = 1'b1;
        if (imem_valid) begin
          w_pc_op      = PC_LOAD;
          w_load_pc    = w_redirect ? branch_address : r_target;
          w_next_state = REQ;
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALTED: begin
        w_drop_valid = 1'b1;
        if (w_redirect) begin
          w_pc_op      = PC_LOAD;
          w_halt_clr   = 1'b1;
          w_next_state = REQ;
        end else begin
          w_halt_set = 1'b1;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_fetch    <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_fetch_valid <= 1'b0;
      r_target      <= RESET_PC;
    end else begin
      if (w_capture) begin
        r_pc_fetch    <= w_pc;
        r_instr       <= imem_data;
        r_fetch_valid <= 1'b1;
      end else if (w_drop_valid) begin
        r_fetch_valid <= 1'b0;
      end
      if (w_latch_target) r_target <= branch_address;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic r_halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_halted <= 1'b0;
    else if (w_halt_clr) r_halted <= 1'b0;
    else if (w_halt_set) r_halted <= 1'b1;
  end

  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  assign imem_addr         = w_pc;
  assign pc_fetch          = r_pc_fetch;
  assign instruction_fetch = r_instr;
  assign fetch_valid       = r_fetch_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts the
// per-cycle outputs, a separate monitor compares them against the DUT.
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [19:0] HALT_WORD = 20'b11111_00000_00000_00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  nop = 2'b00;
  logic [1:0]  select_pc_mux = 2'b00;
  logic [15:0] branch_address = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [19:0] imem_data;
  logic        imem_valid = 1'b0;
  logic [15:0] pc_fetch;
  logic [19:0] instruction_fetch;
  logic        fetch_valid;
  logic        halted;
  logic        plant_halt = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .nop               (nop),
    .select_pc_mux     (select_pc_mux),
    .branch_address    (branch_address),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .imem_valid        (imem_valid),
    .pc_fetch          (pc_fetch),
    .instruction_fetch (instruction_fetch),
    .fetch_valid       (fetch_valid),
    .halted            (halted)
  );

  // Program memory contents: an address-derived pattern, optionally with a
  // halt instruction planted at address 3.
  function automatic logic [19:0] mem_word(input logic [15:0] a, input logic plant);
    if (plant && a == 16'h0003) return HALT_WORD;
    return {a[3:0], a} ^ 20'hA5C3F;
  endfunction

  assign imem_data = mem_word(imem_addr, plant_halt);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-stream level) -----------
  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        fv;
    logic [15:0] pcf;
    logic [19:0] ins;
    logic        hlt;
  } exp_t;

  exp_t        sb_q[$];
  logic        mon_en = 1'b0;

  logic [15:0] m_stream;     // address of the next instruction in program order
  logic        m_idle;       // first cycle out of reset, no request yet
  logic        m_holding;    // presented instruction not yet accepted by decode
  logic        m_killing;    // a request from before a redirect is still outstanding
  logic [15:0] m_kill_addr;
  logic        m_hstate;     // fetch stopped on a halt instruction
  logic        m_halted;
  logic        m_fv;
  logic [15:0] m_pcf;
  logic [19:0] m_ins;
  int          req_age;

  function automatic logic m_req();
    return !m_idle && !m_holding && !m_hstate;
  endfunction

  function automatic logic [15:0] m_addr();
    return m_killing ? m_kill_addr : m_stream;
  endfunction

  task automatic model_reset();
    m_stream = 16'h0000; m_idle = 1'b1; m_holding = 1'b0; m_killing = 1'b0;
    m_kill_addr = 16'h0000; m_hstate = 1'b0; m_halted = 1'b0;
    m_fv = 1'b0; m_pcf = 16'h0000; m_ins = 20'h0; req_age = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input logic stall, input logic redir, input logic [15:0] br,
                            input logic v);
    logic        prev_req;
    logic [15:0] prev_addr;
    prev_req  = m_req();
    prev_addr = m_addr();
    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) m_stream = br;
    end else if (m_hstate) begin
      m_fv = 1'b0;
      if (redir) begin m_stream = br; m_hstate = 1'b0; m_halted = 1'b0; end
      else m_halted = 1'b1;
    end else if (m_holding) begin
      if (redir) begin
        m_stream = br; m_holding = 1'b0; m_fv = 1'b0;
      end else if (!stall) begin
        m_holding = 1'b0;
        if (HALT_EN && m_ins[19:15] == 5'b11111) m_hstate = 1'b1;
      end
    end else if (m_killing) begin
      if (redir) m_stream = br;
      if (v) m_killing = 1'b0;
    end else if (v && !redir) begin
      m_fv = 1'b1; m_pcf = m_stream; m_ins = mem_word(m_stream, plant_halt);
      m_stream = m_stream + 16'd1;
      if (stall) m_holding = 1'b1;
      else if (HALT_EN && m_ins[19:15] == 5'b11111) m_hstate = 1'b1;
    end else begin
      m_fv = 1'b0;
      if (redir) begin
        if (!v) begin m_killing = 1'b1; m_kill_addr = m_stream; end
        m_stream = br;
      end
    end
    if (prev_req && !v && m_req() && m_addr() == prev_addr) req_age++;
    else req_age = 0;
  endtask

  // One clock cycle: drive inputs on the falling edge, advance the model,
  // queue the outputs expected after the next rising edge.
  // lat < 0: random memory latency; otherwise wait cycles before imem_valid.
  task automatic step(input logic [1:0] nop_v, input logic [1:0] sel_v,
                      input logic [15:0] br_v, input int lat);
    logic v;
    exp_t e;
    @(negedge clk);
    if (lat < 0) v = m_req() && ($urandom_range(0, 99) < 60);
    else         v = m_req() && (req_age >= lat);
    nop = nop_v; select_pc_mux = sel_v; branch_address = br_v; imem_valid = v;
    model_edge(nop_v != 2'b00, sel_v == 2'b01, br_v, v);
    e.req = m_req(); e.addr = m_addr(); e.fv = m_fv;
    e.pcf = m_pcf;   e.ins = m_ins;     e.hlt = m_halted;
    sb_q.push_back(e);
    mon_en = 1'b1;
    @(posedge clk); #2;
  endtask

  // ---------------- monitor ----------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("imem_req", imem_req, e.req);
          if (e.req) check("imem_addr", imem_addr, e.addr);
          check("fetch_valid", fetch_valid, e.fv);
          if (e.fv) begin
            check("pc_fetch", pc_fetch, e.pcf);
            check("instruction_fetch", instruction_fetch, e.ins);
          end
          check("halted", halted, e.hlt);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req, 1'b0);
    check({tag, "_addr"},  imem_addr, 16'h0000);
    check({tag, "_pcf"},   pc_fetch, 16'h0000);
    check({tag, "_ins"},   instruction_fetch, 20'h0);
    check({tag, "_fv"},    fetch_valid, 1'b0);
    check({tag, "_halt"},  halted, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    logic [1:0]  n_v, s_v;
    logic [15:0] b_v;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check_reset_outputs("reset");

    // Zero-latency sequential fetch: addresses 0,1,2,3, pc_fetch one cycle behind.
    step(2'b00, 2'b00, 16'h0, 0);
    check("seq_addr0", imem_addr, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      step(2'b00, 2'b00, 16'h0, 0);
      check("seq_addr", imem_addr, 16'(i));
      check("seq_pcf", pc_fetch, 16'(i - 1));
    end

    // Stall for three cycles right as pc=5 is fetched.
    step(2'b00, 2'b00, 16'h0, 0);
    step(2'b00, 2'b00, 16'h0, 0);
    check("pre_stall_addr", imem_addr, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 2'b00, 16'h0, 0);
      check("stall_pcf", pc_fetch, 16'h0005);
      check("stall_req", imem_req, 1'b0);
    end
    step(2'b00, 2'b00, 16'h0, 0);
    step(2'b00, 2'b00, 16'h0, 0);
    check("post_stall_pcf", pc_fetch, 16'h0006);

    // Two-cycle latency memory, redirect while the request at pc=8 is pending.
    step(2'b00, 2'b00, 16'h0, 0);
    check("pending_addr", imem_addr, 16'h0008);
    step(2'b00, 2'b00, 16'h0, 2);
    step(2'b00, 2'b01, 16'h0040, 2);
    check("kill_fv", fetch_valid, 1'b0);
    step(2'b00, 2'b00, 16'h0, 2);
    check("kill_done_addr", imem_addr, 16'h0040);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 16'h0, 2);
    check("redir_pcf", pc_fetch, 16'h0040);
    check("redir_fv", fetch_valid, 1'b1);

    // Redirect concurrent with a stall: redirect wins.
    step(2'b01, 2'b01, 16'h0010, 0);
    check("redir_over_stall_addr", imem_addr, 16'h0010);

    // Wrap from 16'hFFFF to 16'h0000.
    step(2'b00, 2'b01, 16'hFFFF, 0);
    check("wrap_pre_addr", imem_addr, 16'hFFFF);
    step(2'b00, 2'b00, 16'h0, 0);
    check("wrap_addr", imem_addr, 16'h0000);
    check("wrap_pcf", pc_fetch, 16'hFFFF);

    if (HALT_EN) begin
      plant_halt = 1'b1;
      step(2'b00, 2'b01, 16'h0003, 0);
      step(2'b00, 2'b00, 16'h0, 0);
      check("halt_present_fv", fetch_valid, 1'b1);
      check("halt_present_ins", instruction_fetch, HALT_WORD);
      step(2'b00, 2'b00, 16'h0, 0);
      check("halted_flag", halted, 1'b1);
      check("halted_req", imem_req, 1'b0);
      step(2'b00, 2'b00, 16'h0, 0);
      step(2'b00, 2'b01, 16'h0020, 0);
      check("resume_addr", imem_addr, 16'h0020);
      check("resume_halted", halted, 1'b0);
      plant_halt = 1'b0;
    end

    // Randomized traffic: stalls, redirects and variable memory latency.
    for (int i = 0; i < 1500; i++) begin
      n_v = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 99) < 10) s_v = 2'b01;
      else begin
        s_v = 2'($urandom_range(0, 2));
        if (s_v == 2'b01) s_v = 2'b11;
      end
      b_v = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      step(n_v, s_v, b_v, -1);
    end

    // Reset asserted mid-request: outputs return to reset values immediately.
    step(2'b00, 2'b01, 16'h0123, 0);
    check("mid_req_active", imem_req, 1'b1);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    check_reset_outputs("reset_release");
    step(2'b00, 2'b00, 16'h0, 0);
    step(2'b00, 2'b00, 16'h0, 0);
    check("after_reset_pcf", pc_fetch, 16'h0000);

    mon_en = 1'b0;
    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
